// File: rtl/bounce_generator.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_generator
//  Description : Contact-bounce emulator. On a start request the output is
//                driven to a new level through a burst of pseudo-random
//                glitches (widths taken from a 16-bit LFSR), then the new
//                level is held for a settle period before completion.
//
//  Ports       : i_Clk     - system clock, rising edge
//                i_Rst     - synchronous active-high reset
//                i_Start   - one-cycle request, sampled only while idle
//                i_Target  - requested final level, latched with i_Start
//                o_Bouncy  - emulated bouncing contact (registered)
//                o_Busy    - sequence in progress
//                o_Done    - one-cycle completion pulse
//                o_Edges   - o_Bouncy transitions in current/last sequence
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bounce_generator #(
    parameter int          BOUNCE_PULSES = 3,
    parameter int          GLITCH_BITS   = 2,
    parameter int          SETTLE_CYCLES = 8,
    parameter bit          INIT_LEVEL    = 1'b0,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Start,
    input  logic       i_Target,
    output logic       o_Bouncy,
    output logic       o_Busy,
    output logic       o_Done,
    output logic [7:0] o_Edges
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_HIGH   = 3'd1;  // output at target level
    localparam logic [2:0] c_ST_LOW    = 3'd2;  // output back at old level
    localparam logic [2:0] c_ST_SETTLE = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    // An all-zero seed would lock the LFSR, so substitute the default.
    localparam logic [15:0] c_SEED_EFF    = (SEED == 16'd0) ? 16'hACE1 : SEED;
    localparam logic [5:0]  c_PULSES      = 6'(BOUNCE_PULSES);
    localparam logic [15:0] c_SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]             r_state;
    logic [15:0]            r_lfsr;
    logic [GLITCH_BITS-1:0] r_seg_cnt;
    logic [5:0]             r_pulse_cnt;
    logic [15:0]            r_settle_cnt;
    logic                   r_target;
    logic                   r_bouncy;
    logic [7:0]             r_edges;

    logic [2:0]             w_state_nxt;
    logic [15:0]            w_lfsr_nxt;
    logic [GLITCH_BITS-1:0] w_seg_cnt_nxt;
    logic [5:0]             w_pulse_cnt_nxt;
    logic [15:0]            w_settle_cnt_nxt;
    logic                   w_target_nxt;
    logic                   w_bouncy_nxt;
    logic [7:0]             w_edges_nxt;

    logic [15:0]            w_lfsr_adv;
    logic [7:0]             w_edges_inc;
    logic                   w_seg_expired;

    // Fibonacci LFSR step; only committed when a glitch segment is loaded,
    // so the width sequence is fully reproducible from reset.
    assign w_lfsr_adv    = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_edges_inc   = (r_edges == 8'hFF) ? r_edges : r_edges + 8'd1;
    assign w_seg_expired = (r_seg_cnt == '0);

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_lfsr_nxt       = r_lfsr;
        w_seg_cnt_nxt    = r_seg_cnt;
        w_pulse_cnt_nxt  = r_pulse_cnt;
        w_settle_cnt_nxt = r_settle_cnt;
        w_target_nxt     = r_target;
        w_bouncy_nxt     = r_bouncy;
        w_edges_nxt      = r_edges;

        case (r_state)
            c_ST_IDLE: begin
                if (i_Start) begin
                    w_target_nxt = i_Target;
                    w_edges_nxt  = 8'd0;
                    if (i_Target != r_bouncy) begin
                        w_bouncy_nxt    = i_Target;
                        w_edges_nxt     = 8'd1;
                        w_pulse_cnt_nxt = 6'd1;
                        w_seg_cnt_nxt   = r_lfsr[GLITCH_BITS-1:0];
                        w_lfsr_nxt      = w_lfsr_adv;
                        w_state_nxt     = c_ST_HIGH;
                    end else begin
                        // Already at the requested level: complete with no toggle.
                        w_state_nxt = c_ST_DONE;
                    end
                end
            end

            c_ST_HIGH: begin
                if (w_seg_expired) begin
                    w_bouncy_nxt  = ~r_target;
                    w_edges_nxt   = w_edges_inc;
                    w_seg_cnt_nxt = r_lfsr[GLITCH_BITS-1:0];
                    w_lfsr_nxt    = w_lfsr_adv;
                    w_state_nxt   = c_ST_LOW;
                end else begin
                    w_seg_cnt_nxt = r_seg_cnt - 1'b1;
                end
            end

            c_ST_LOW: begin
                if (w_seg_expired) begin
                    w_bouncy_nxt = r_target;
                    w_edges_nxt  = w_edges_inc;
                    if (r_pulse_cnt == c_PULSES) begin
                        w_settle_cnt_nxt = c_SETTLE_LAST;
                        w_state_nxt      = c_ST_SETTLE;
                    end else begin
                        w_pulse_cnt_nxt = r_pulse_cnt + 6'd1;
                        w_seg_cnt_nxt   = r_lfsr[GLITCH_BITS-1:0];
                        w_lfsr_nxt      = w_lfsr_adv;
                        w_state_nxt     = c_ST_HIGH;
                    end
                end else begin
                    w_seg_cnt_nxt = r_seg_cnt - 1'b1;
                end
            end

            c_ST_SETTLE: begin
                if (r_settle_cnt == 16'd0) begin
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt - 16'd1;
                end
            end

            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state      <= c_ST_IDLE;
            r_lfsr       <= c_SEED_EFF;
            r_seg_cnt    <= '0;
            r_pulse_cnt  <= 6'd0;
            r_settle_cnt <= 16'd0;
            r_target     <= INIT_LEVEL;
            r_bouncy     <= INIT_LEVEL;
            r_edges      <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_seg_cnt    <= w_seg_cnt_nxt;
            r_pulse_cnt  <= w_pulse_cnt_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_target     <= w_target_nxt;
            r_bouncy     <= w_bouncy_nxt;
            r_edges      <= w_edges_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_Bouncy = r_bouncy;
    assign o_Busy   = (r_state == c_ST_HIGH) || (r_state == c_ST_LOW) || (r_state == c_ST_SETTLE);
    assign o_Done   = (r_state == c_ST_DONE);
    assign o_Edges  = r_edges;

endmodule
`default_nettype wire

// File: tb/tb_bounce_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bounce_generator
//  Description : Directed self-checking bench for bounce_generator with
//                default parameters. Expected glitch widths come from a
//                reference LFSR; a behavioural debounce filter downstream
//                confirms a single clean level change per request.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bounce_generator;

    localparam int c_PULSES    = 3;
    localparam int c_GBITS     = 2;
    localparam int c_SETTLE    = 8;
    localparam int c_DEB_LIMIT = 5;
    localparam int c_EDGES     = 2 * c_PULSES + 1;

    logic       r_clk    = 1'b0;
    logic       r_rst    = 1'b1;
    logic       r_start  = 1'b0;
    logic       r_target = 1'b0;
    logic       w_bouncy;
    logic       w_busy;
    logic       w_done;
    logic [7:0] w_edges;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] r_model_lfsr;

    // Downstream debounce filter: level follows the input only after
    // c_DEB_LIMIT consecutive samples that differ from the current level.
    logic r_deb         = 1'b0;
    int   r_deb_cnt     = 0;
    int   r_deb_changes = 0;

    bounce_generator #(
        .BOUNCE_PULSES (c_PULSES),
        .GLITCH_BITS   (c_GBITS),
        .SETTLE_CYCLES (c_SETTLE),
        .INIT_LEVEL    (1'b0),
        .SEED          (16'hACE1)
    ) u_dut (
        .i_Clk    (r_clk),
        .i_Rst    (r_rst),
        .i_Start  (r_start),
        .i_Target (r_target),
        .o_Bouncy (w_bouncy),
        .o_Busy   (w_busy),
        .o_Done   (w_done),
        .o_Edges  (w_edges)
    );

    always #5 r_clk = ~r_clk;

    always @(posedge r_clk) begin
        if (w_bouncy != r_deb) begin
            if (r_deb_cnt == c_DEB_LIMIT - 1) begin
                r_deb         <= w_bouncy;
                r_deb_cnt     <= 0;
                r_deb_changes <= r_deb_changes + 1;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1;
            end
        end else begin
            r_deb_cnt <= 0;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge r_clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic check_idle(input string tag, input int lvl, input int edges);
        check({tag, "_bouncy"}, int'(w_bouncy), lvl);
        check({tag, "_busy"},   int'(w_busy),   0);
        check({tag, "_done"},   int'(w_done),   0);
        check({tag, "_edges"},  int'(w_edges),  edges);
    endtask

    // Full level-change sequence checked cycle by cycle against the model.
    task automatic run_seq(input logic tgt, input bit disturb);
        int   w[2*c_PULSES];
        int   total_seg;
        int   total;
        int   trans;
        int   dones;
        int   deb0;
        int   seg;
        int   acc;
        int   exp_b;
        int   exp_busy;
        int   exp_done;
        int   exp_edges;
        logic prev;

        total_seg = 0;
        for (int i = 0; i < 2 * c_PULSES; i++) begin
            w[i]         = int'(r_model_lfsr[c_GBITS-1:0]) + 1;
            r_model_lfsr = lfsr_step(r_model_lfsr);
            total_seg   += w[i];
        end
        total = total_seg + c_SETTLE + 1;
        trans = 0;
        dones = 0;
        deb0  = r_deb_changes;
        prev  = w_bouncy;

        r_target = tgt;
        r_start  = 1'b1;
        tick();
        r_start  = 1'b0;

        for (int c = 0; c < total; c++) begin
            if (c < total_seg) begin
                seg = 0;
                acc = w[0];
                while (c >= acc) begin
                    seg++;
                    acc += w[seg];
                end
                exp_b     = (seg % 2 == 0) ? int'(tgt) : int'(!tgt);
                exp_edges = seg + 1;
                exp_busy  = 1;
                exp_done  = 0;
            end else if (c < total_seg + c_SETTLE) begin
                exp_b     = int'(tgt);
                exp_edges = c_EDGES;
                exp_busy  = 1;
                exp_done  = 0;
            end else begin
                exp_b     = int'(tgt);
                exp_edges = c_EDGES;
                exp_busy  = 0;
                exp_done  = 1;
            end
            if (w_bouncy != prev) trans++;
            prev = w_bouncy;
            if (w_done) dones++;
            check($sformatf("c%0d_bouncy", c), int'(w_bouncy), exp_b);
            check($sformatf("c%0d_busy", c),   int'(w_busy),   exp_busy);
            check($sformatf("c%0d_done", c),   int'(w_done),   exp_done);
            check($sformatf("c%0d_edges", c),  int'(w_edges),  exp_edges);
            if (disturb && (c % 3 == 1)) begin
                r_start  = 1'b1;
                r_target = (c % 2 == 1);
            end
            tick();
            r_start = 1'b0;
        end

        check_idle("post_seq", int'(tgt), c_EDGES);
        check("transitions", trans, c_EDGES);
        check("done_pulses", dones, 1);
        check("deb_changes", r_deb_changes - deb0, 1);
        check("deb_level", int'(r_deb), int'(tgt));
    endtask

    initial begin : main
        int w0, w1, w2;
        logic [15:0] tmp;

        // Reset, then idle
        repeat (3) tick();
        r_rst = 1'b0;
        r_model_lfsr = 16'hACE1;
        for (int i = 0; i < 20; i++) check_idle($sformatf("idle%0d", i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 19) check_idle("idle_end", 0, 0);
        end

        // 0 -> 1 bounce sequence
        run_seq(1'b1, 1'b0);

        // Same-level request: immediate completion, no transitions
        r_target = 1'b1;
        r_start  = 1'b1;
        tick();
        r_start  = 1'b0;
        check("same_done",   int'(w_done),   1);
        check("same_busy",   int'(w_busy),   0);
        check("same_bouncy", int'(w_bouncy), 1);
        check("same_edges",  int'(w_edges),  0);
        tick();
        check_idle("same_after", 1, 0);

        // 1 -> 0 with start requests during the sequence (must be ignored)
        run_seq(1'b0, 1'b1);

        // Reset in the low segment of the second pulse
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        tmp = 16'hACE1;
        w0 = int'(tmp[c_GBITS-1:0]) + 1; tmp = lfsr_step(tmp);
        w1 = int'(tmp[c_GBITS-1:0]) + 1; tmp = lfsr_step(tmp);
        w2 = int'(tmp[c_GBITS-1:0]) + 1;
        r_target = 1'b1;
        r_start  = 1'b1;
        tick();
        r_start  = 1'b0;
        repeat (w0 + w1 + w2) tick();
        check("mid_bouncy", int'(w_bouncy), 0);
        check("mid_busy",   int'(w_busy),   1);
        check("mid_edges",  int'(w_edges),  4);
        r_rst = 1'b1;
        tick();
        check_idle("rst_mid", 0, 0);
        r_rst = 1'b0;
        tick();
        check_idle("rst_after", 0, 0);

        // Replay from reset must reproduce the first run's widths
        r_model_lfsr = 16'hACE1;
        run_seq(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bounce_generator.md
Name: bounce_generator

Overview:
Synthesizable contact-bounce emulator: the transmit-side counterpart of the debounce filter. On command it drives a single-bit output to a new level through a burst of pseudo-random glitches, then holds the level stably. It is used as an on-chip stimulus source in front of debounce filters, for board demos and for end-to-end self-checking benches without a physical switch.

Parameters:
BOUNCE_PULSES, 3, number of glitch pulses (output at target, then back to old level) before the final settle; legal range 1..63.
GLITCH_BITS, 2, glitch segment width is 1..2^GLITCH_BITS cycles; legal range 1..8.
SETTLE_CYCLES, 8, cycles the final level is held before completion; legal range 1..65535.
INIT_LEVEL, 0, level of o_Bouncy after reset.
SEED, 16'hACE1, LFSR reset value; if 0, 16'hACE1 is used instead.

Ports:
i_Clk  input  1  system clock, all logic on rising edge.
i_Rst  input  1  synchronous, active-high reset.
i_Start  input  1  one-cycle request to move o_Bouncy to i_Target; sampled only in IDLE.
i_Target  input  1  requested final level, sampled with i_Start.
o_Bouncy  output  1  emulated bouncing contact, registered.
o_Busy  output  1  high while a bounce sequence is in progress.
o_Done  output  1  one-cycle pulse at sequence completion.
o_Edges  output  8  number of o_Bouncy transitions in the current/last sequence; cleared at each accepted start.

Behaviour:
- Reset (i_Rst high at a clock edge, any state, including mid-sequence): state IDLE, o_Bouncy=INIT_LEVEL, o_Busy=0, o_Done=0, o_Edges=0, LFSR=SEED (or 16'hACE1), counters 0. Reset has priority over everything.
- LFSR: 16-bit Fibonacci, feedback = l[15]^l[13]^l[12]^l[10], shift left, feedback enters bit 0. Advances only when a glitch segment is loaded, never otherwise, so sequences are deterministic from reset.
- Segment load: counter <= current LFSR[GLITCH_BITS-1:0]; LFSR advances the same cycle; segment lasts counter+1 cycles (1..2^GLITCH_BITS).
- States: IDLE, HIGH_SEG (output at target), LOW_SEG (output at old level), SETTLE, DONE.
- IDLE: o_Busy=0. i_Start=1 and i_Target!=o_Bouncy -> next cycle: o_Bouncy=i_Target, o_Busy=1, o_Edges=1, pulse counter=1, load segment, go HIGH_SEG. i_Start=1 and i_Target==o_Bouncy -> go DONE, no toggle, o_Edges=0. i_Start=0 -> stay.
- HIGH_SEG: on segment expiry -> o_Bouncy=old level, o_Edges+1, load segment, go LOW_SEG.
- LOW_SEG: on expiry -> o_Bouncy=target, o_Edges+1; if pulse counter==BOUNCE_PULSES go SETTLE (settle counter=SETTLE_CYCLES-1), else pulse counter+1, load segment, go HIGH_SEG.
- SETTLE: o_Bouncy held at target; after SETTLE_CYCLES cycles at target go DONE.
- DONE: o_Done=1 and o_Busy=0 for exactly one cycle, then IDLE. o_Edges holds until the next accepted start.
- Totals per level-change sequence: exactly 2*BOUNCE_PULSES+1 transitions, final level = target; the longest glitch segment is 2^GLITCH_BITS cycles.
- i_Start while o_Busy=1 or in DONE: ignored, no queueing. i_Target is latched at start; later changes are ignored.
- o_Edges saturates at 255.

Test Plan:
- Reset then idle 20 cycles -> o_Bouncy=0, o_Busy=0, o_Done=0, o_Edges=0 throughout.
- Defaults, i_Start=1,i_Target=1 one cycle -> o_Bouncy=1 next cycle; exactly 7 transitions; every segment before settle lasts 1..4 cycles; final 1 held >=8 cycles; one o_Done pulse; o_Edges=7; LFSR-derived widths match the reference model from seed 16'hACE1.
- After the above, i_Start,i_Target=1 -> no transitions, o_Done pulses 1 cycle after start, o_Edges=0.
- i_Start pulses during o_Busy -> ignored; sequence identical to the undisturbed run, single o_Done.
- i_Rst asserted in LOW_SEG of the 2nd pulse -> next cycle o_Bouncy=0, o_Busy=0, o_Edges=0; a new start replays the same widths as the first run after reset.
- Chained into Debounce_Filter with DEBOUNCE_LIMIT=5, 0->1 then 1->0 requests -> o_Debounced changes exactly once per request, to 1 then to 0, and never glitches.
